// File: rtl/div_seq32_if.sv
// rtl/div_seq32_if.sv - request/result bundle between the EX stage and the sequential divider
interface div_seq32_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             flush;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;

  modport master (
    output start, flush, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero
  );

  modport slave (
    input  start, flush, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, div_zero
  );
endinterface

// File: rtl/div_seq32.sv
// rtl/div_seq32.sv - restoring shift-and-subtract divider for DIV/DIVU, one quotient bit per clock
// Optional DIV_SEQ32_EARLY_OUT_EN skips iteration when |divisor| > |dividend|.
module div_seq32 #(
  parameter int WIDTH = 32
) (
  input logic        clk,
  input logic        rst_n,
  div_seq32_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, quo, dsr;
  logic             qsign, rsign, dz;
  logic [WIDTH-1:0] quotient_q, remainder_q;
  logic             div_zero_q;
  logic             accept, skip;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted, trial;
  logic             early;

  assign accept  = bus.start && !bus.flush;
  assign a_neg   = bus.is_signed & bus.dividend[WIDTH-1];
  assign b_neg   = bus.is_signed & bus.divisor[WIDTH-1];
  assign a_mag   = a_neg ? -bus.dividend : bus.dividend;
  assign b_mag   = b_neg ? -bus.divisor : bus.divisor;
  assign shifted = {rem, quo[WIDTH-1]};
  assign trial   = shifted - {1'b0, dsr};

`ifdef DIV_SEQ32_EARLY_OUT_EN
  assign early = b_mag > a_mag;
`else
  assign early = 1'b0;
`endif
  // Zero divisor and early-out share the FIX path: quotient magnitude 0, remainder |dividend|.
  assign skip = (bus.divisor == '0) || early;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = skip ? FIX : RUN;
      RUN:     if (bus.flush) state_nxt = IDLE;
               else if (cnt == '0) state_nxt = FIX;
      FIX:     state_nxt = bus.flush ? IDLE : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == RUN) || (state == FIX);
    bus.done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem         <= '0;
      quo         <= '0;
      dsr         <= '0;
      cnt         <= '0;
      qsign       <= 1'b0;
      rsign       <= 1'b0;
      dz          <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          dsr   <= b_mag;
          qsign <= a_neg ^ b_neg;
          rsign <= a_neg;
          dz    <= (bus.divisor == '0);
          cnt   <= CW'(WIDTH - 1);
          if (skip) begin
            rem <= a_mag;
            quo <= '0;
          end else begin
            rem <= '0;
            quo <= a_mag;
          end
        end
        RUN: begin
          // trial[WIDTH] is the borrow: set means the subtraction did not fit.
          quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
          rem <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
          cnt <= cnt - 1'b1;
        end
        FIX: if (!bus.flush) begin
          quotient_q  <= dz ? '1 : (qsign ? -quo : quo);
          remainder_q <= rsign ? -rem : rem;
          div_zero_q  <= dz;
        end
        default: ;
      endcase
    end
  end

  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.div_zero  = div_zero_q;
endmodule
